// File: rtl/sw_rate_timer.sv
`default_nettype none
// ============================================================================
// Module   : sw_rate_timer
// Brief    : Periodic tick generator; a synchronised switch picks the period.
// Revision : 1.0
// ============================================================================
module sw_rate_timer #(
    parameter int          DATA_WIDTH = 32,
    parameter int unsigned R0         = 3,
    parameter int unsigned R1         = 10,
    parameter int unsigned R2         = 100,
    parameter int unsigned R3         = 5000
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_mode,
    input  logic                  i_start,
    input  logic [1:0]            i_sw,
    output logic                  o_tick,
    output logic [DATA_WIDTH-1:0] o_count,
    output logic                  o_busy,
    output logic [DATA_WIDTH-1:0] o_limit
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [DATA_WIDTH-1:0] c_ONE  = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] c_LIM0 = DATA_WIDTH'(R0);
    localparam logic [DATA_WIDTH-1:0] c_LIM1 = DATA_WIDTH'(R1);
    localparam logic [DATA_WIDTH-1:0] c_LIM2 = DATA_WIDTH'(R2);
    localparam logic [DATA_WIDTH-1:0] c_LIM3 = DATA_WIDTH'(R3);

    // A zero limit would never terminate, so it behaves as a one-cycle period.
    function automatic logic [DATA_WIDTH-1:0] eff_limit(input logic [DATA_WIDTH-1:0] lim);
        return (lim == '0) ? c_ONE : lim;
    endfunction

    localparam logic [DATA_WIDTH-1:0] c_EFF0 = eff_limit(c_LIM0);

    state_t                  state_q, state_d;
    logic [1:0]              sw_meta_q;
    logic [1:0]              sw_sync_q;
    logic [DATA_WIDTH-1:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0]   limit_q, limit_d;
    logic                    tick_q, tick_d;
    logic [DATA_WIDTH-1:0]   w_sel_limit;
    logic                    w_terminal;

    always_comb begin
        w_sel_limit = c_LIM0;
        case (sw_sync_q)
            2'b00:   w_sel_limit = c_LIM0;
            2'b01:   w_sel_limit = c_LIM1;
            2'b10:   w_sel_limit = c_LIM2;
            default: w_sel_limit = c_LIM3;
        endcase
    end

    assign w_terminal = (state_q == S_RUN) && i_enable && (count_q == (limit_q - c_ONE));

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        limit_d = limit_q;
        tick_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                count_d = '0;
                limit_d = eff_limit(w_sel_limit);
                if (i_enable && (!i_mode || i_start)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (w_terminal) begin
                    count_d = '0;
                    tick_d  = 1'b1;
                    limit_d = eff_limit(w_sel_limit);
                    if (i_mode) begin
                        state_d = S_IDLE;
                    end
                end else if (i_enable) begin
                    count_d = count_q + c_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            sw_meta_q <= 2'b00;
            sw_sync_q <= 2'b00;
            count_q   <= '0;
            limit_q   <= c_EFF0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sw_meta_q <= i_sw;
            sw_sync_q <= sw_meta_q;
            count_q   <= count_d;
            limit_q   <= limit_d;
            tick_q    <= tick_d;
        end
    end

    assign o_tick  = tick_q;
    assign o_count = count_q;
    assign o_busy  = (state_q == S_RUN);
    assign o_limit = limit_q;

endmodule
`default_nettype wire

// File: tb/tb_sw_rate_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sw_rate_timer
// Brief    : Vector-table bench for sw_rate_timer plus a zero-limit instance.
// Revision : 1.0
// ============================================================================
module tb_sw_rate_timer;

    logic        clk = 1'b0;
    logic        rst, en, mode, start;
    logic [1:0]  sw;
    logic        tick;
    logic [31:0] cnt, lim;
    logic        busy;

    logic        rst2, en2;
    logic [1:0]  sw2;
    logic        tick2, busy2;
    logic [31:0] cnt2, lim2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sw_rate_timer #(.DATA_WIDTH(32)) u_dut (
        .i_clk(clk), .i_reset(rst), .i_enable(en), .i_mode(mode),
        .i_start(start), .i_sw(sw), .o_tick(tick), .o_count(cnt),
        .o_busy(busy), .o_limit(lim)
    );

    sw_rate_timer #(.DATA_WIDTH(32), .R1(0)) u_dut_zero (
        .i_clk(clk), .i_reset(rst2), .i_enable(en2), .i_mode(1'b0),
        .i_start(1'b0), .i_sw(sw2), .o_tick(tick2), .o_count(cnt2),
        .o_busy(busy2), .o_limit(lim2)
    );

    typedef struct {
        logic        rst, en, mode, start;
        logic [1:0]  sw;
        logic        tick;
        logic [31:0] cnt;
        logic        busy;
        logic [31:0] lim;
    } vec_t;

    vec_t vq[$];

    task automatic push(input logic r, input logic e, input logic m, input logic s,
                        input logic [1:0] w, input logic t, input int c,
                        input logic b, input int l);
        vec_t v;
        v.rst = r; v.en = e; v.mode = m; v.start = s; v.sw = w;
        v.tick = t; v.cnt = 32'(c); v.busy = b; v.lim = 32'(l);
        vq.push_back(v);
    endtask

    task automatic check2(input string name, input logic t, input int c,
                          input logic b, input int l);
        checks++;
        if (tick2 !== t || cnt2 !== 32'(c) || busy2 !== b || lim2 !== 32'(l)) begin
            errors++;
            $display("FAIL %s: got tick=%0b count=%0d busy=%0b limit=%0d, want tick=%0b count=%0d busy=%0b limit=%0d",
                     name, tick2, cnt2, busy2, lim2, t, c, b, l);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0; start = 1'b0; sw = 2'b00;
        rst2 = 1'b1; en2 = 1'b0; sw2 = 2'b00;

        // Reset, then continuous R0=3 period
        push(1,0,0,0,2'd0, 0,0,0,3);
        push(1,0,0,0,2'd0, 0,0,0,3);
        push(0,1,0,0,2'd0, 0,0,1,3);
        push(0,1,0,0,2'd0, 0,1,1,3);
        push(0,1,0,0,2'd0, 0,2,1,3);
        push(0,1,0,0,2'd0, 1,0,1,3);
        push(0,1,0,0,2'd0, 0,1,1,3);
        push(0,1,0,0,2'd0, 0,2,1,3);
        push(0,1,0,0,2'd0, 1,0,1,3);
        push(0,1,0,0,2'd0, 0,1,1,3);
        push(0,1,0,0,2'd0, 0,2,1,3);
        // Pause across the terminal cycle
        for (int i = 0; i < 5; i++) push(0,0,0,0,2'd0, 0,2,1,3);
        push(0,1,0,0,2'd0, 1,0,1,3);
        push(0,1,0,0,2'd0, 0,1,1,3);
        // Switch to 01: visible only after sync and a period boundary
        push(0,1,0,0,2'd1, 0,2,1,3);
        push(0,1,0,0,2'd1, 1,0,1,3);
        push(0,1,0,0,2'd1, 0,1,1,3);
        push(0,1,0,0,2'd1, 0,2,1,3);
        push(0,1,0,0,2'd1, 1,0,1,10);
        for (int c = 1; c <= 4; c++) push(0,1,0,0,2'd1, 0,c,1,10);
        // Switch to 10 mid-period: current period of 10 completes
        for (int c = 5; c <= 9; c++) push(0,1,0,0,2'd2, 0,c,1,10);
        push(0,1,0,0,2'd2, 1,0,1,100);
        for (int c = 1; c <= 57; c++) push(0,1,0,0,2'd2, 0,c,1,100);
        // Reset mid-run at count 57
        push(1,1,0,0,2'd2, 0,0,0,3);
        push(0,0,0,0,2'd2, 0,0,0,3);
        push(0,0,0,0,2'd2, 0,0,0,3);
        push(0,0,0,0,2'd2, 0,0,0,100);
        push(0,0,0,0,2'd0, 0,0,0,100);
        push(0,0,0,0,2'd0, 0,0,0,100);
        push(0,0,0,0,2'd0, 0,0,0,3);
        // One-shot
        push(0,1,1,0,2'd0, 0,0,0,3);
        push(0,1,1,1,2'd0, 0,0,1,3);
        push(0,1,1,0,2'd0, 0,1,1,3);
        push(0,1,1,0,2'd0, 0,2,1,3);
        push(0,1,1,0,2'd0, 1,0,0,3);
        push(0,1,1,0,2'd0, 0,0,0,3);
        push(0,1,1,0,2'd0, 0,0,0,3);
        // Start while disabled is dropped; mode toggle mid-period is harmless
        push(0,0,1,1,2'd0, 0,0,0,3);
        push(0,1,1,0,2'd0, 0,0,0,3);
        push(0,1,1,1,2'd0, 0,0,1,3);
        push(0,1,0,0,2'd0, 0,1,1,3);
        push(0,1,1,0,2'd0, 0,2,1,3);
        push(0,1,1,0,2'd0, 1,0,0,3);
        push(0,1,1,0,2'd0, 0,0,0,3);
        push(0,1,1,0,2'd0, 0,0,0,3);

        foreach (vq[i]) begin
            @(negedge clk);
            rst = vq[i].rst; en = vq[i].en; mode = vq[i].mode;
            start = vq[i].start; sw = vq[i].sw;
            @(posedge clk);
            #1;
            checks++;
            if (tick !== vq[i].tick || cnt !== vq[i].cnt ||
                busy !== vq[i].busy || lim !== vq[i].lim) begin
                errors++;
                $display("FAIL vec%0d: got tick=%0b count=%0d busy=%0b limit=%0d, want tick=%0b count=%0d busy=%0b limit=%0d",
                         i, tick, cnt, busy, lim, vq[i].tick, vq[i].cnt, vq[i].busy, vq[i].lim);
            end
        end

        // Zero limit on switch 01 degenerates to a tick every enabled cycle
        @(negedge clk); rst2 = 1'b1;
        @(posedge clk); #1;
        check2("zero_reset", 0, 0, 0, 3);
        @(negedge clk); rst2 = 1'b0; sw2 = 2'b01;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check2("zero_sync_wait", 0, 0, 0, 3);
        @(posedge clk); #1;
        check2("zero_limit", 0, 0, 0, 1);
        @(negedge clk); en2 = 1'b1;
        @(posedge clk); #1;
        check2("zero_entry", 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check2("zero_tick_held", 1, 0, 1, 1);
        end
        @(negedge clk); en2 = 1'b0;
        @(posedge clk); #1;
        check2("zero_paused", 0, 0, 1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sw_rate_timer.md
Name: sw_rate_timer

Overview:
- Switch-selected periodic timer. The 2-bit switch input picks one of four parametrised period limits.
- A counter runs against the selected limit and emits a one-cycle tick at each period end, in either continuous or one-shot mode.
- Switch inputs are synchronised, and a new selection only takes effect at a period boundary.
- Sits between board switches and LED/blink or sample-rate logic in the prueba top level.

Parameters:
- DATA_WIDTH, 32, width of counter, limit and count outputs.
- R0, 3, period limit for i_sw=2'b00 (cycles).
- R1, 10, period limit for i_sw=2'b01.
- R2, 100, period limit for i_sw=2'b10.
- R3, 5000, period limit for i_sw=2'b11.

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_reset  input  1  reset, synchronous and active-high.
- i_enable  input  1  run/gate; low pauses counting.
- i_mode  input  1  0 = continuous, 1 = one-shot.
- i_start  input  1  one-shot trigger; sampled only in IDLE.
- i_sw  input  2  period select; asynchronous to i_clk.
- o_tick  output  1  registered one-cycle pulse at period end.
- o_count  output  DATA_WIDTH  current count value.
- o_busy  output  1  high while state is RUN.
- o_limit  output  DATA_WIDTH  active effective limit.

Behaviour:
- Reset (synchronous, highest priority, also mid-run): state IDLE, o_count=0, o_tick=0, o_busy=0, o_limit=eff(R0), sync flops=2'b00.
- Switch sync:
  - 2-flop synchroniser on i_sw giving sel_s.
  - A change on i_sw is visible in sel_s after 2 clock edges.
- Limit table: R0..R3 truncated to DATA_WIDTH. eff(L) = 1 if L==0, else L.
- Active limit (o_limit) loads eff(table[sel_s]):
  - every cycle in IDLE;
  - in the terminal cycle T.
  - Otherwise it holds. A switch change mid-period never alters the current period.
- States: IDLE and RUN.
- IDLE:
  - o_busy=0, o_count=0.
  - Go to RUN when i_enable=1 and (i_mode=0 or i_start=1). o_count stays 0 on the entry edge.
  - i_start with i_enable=0 is ignored and not remembered.
- RUN:
  - o_busy=1.
  - If i_enable=0: o_count holds and no tick is generated (pause). This holds in both modes; the block does not return to IDLE.
  - If i_enable=1 and o_count != o_limit-1: o_count += 1.
  - T = RUN and i_enable=1 and o_count == o_limit-1. On T:
    - o_count <= 0; o_tick <= 1 for the next cycle only; active limit reloads;
    - if i_mode=1 go to IDLE, else stay in RUN.
- i_mode is only acted on at T or in IDLE. Toggling it mid-period is harmless.
- Latency:
  - With RUN entered at edge k, T occurs in the cycle after edge k+L-1.
  - o_tick is high for one cycle after edge k+L.
  - Continuous ticks repeat every L enabled cycles.
- L=1: T every enabled cycle, so o_tick stays high continuously while enabled.
- Pause spanning T: the tick is delayed until enable returns. No tick is lost or duplicated.
- o_tick is never high for more than one cycle, except in the L=1 case.
- Counter never exceeds o_limit-1; wrap is exact with no overflow at DATA_WIDTH.

Test Plan:
- Reset, i_sw=00, i_mode=0, i_enable=1 held -> o_busy=1 after 1 edge; o_tick pulses every 3 cycles; o_count sequence 0,1,2,0,...; o_limit=3.
- Continuous with i_sw=01, switch to 10 mid-period at o_count=4 -> current period still ends at count 9 with a tick; next period counts to 99; o_limit changes to 100 only at the wrap.
- i_mode=1, i_sw=00, i_start pulsed once -> exactly one o_tick, 3 cycles after RUN entry; o_busy returns to 0; no further ticks. A second i_start gives one more tick.
- Continuous R0=3, drop i_enable for 5 cycles at o_count=2 -> o_count holds at 2, no tick; tick appears the cycle after enable returns; no duplicate.
- Assert i_reset at o_count=57 in a 100 period -> next cycle o_count=0, o_busy=0, o_tick=0, o_limit=3; counting restarts only when i_reset is low and enabled.
- Parameter override R1=0, i_sw=01 -> o_limit=1; o_tick continuously high while enabled; o_count stays 0.
